// File: rtl/div_seq_ctrl.sv
// Sequential unsigned restoring divider: one quotient bit per cycle.
// The partial register is packed {remainder, quotient}. A zero divisor skips
// the iteration and reports all-ones quotient and the dividend as remainder.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [2*WIDTH-1:0]     part;
    logic [2*WIDTH-1:0]     part_step;
    logic [WIDTH-1:0]       dvsr;

    // One restoring step: shift the partial left, trial-subtract the divisor
    // from the upper WIDTH+1 bits, keep the difference when it did not borrow.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   d
    );
        logic [WIDTH:0] t;
        t = p[2*WIDTH-1:WIDTH-1] - {1'b0, d};
        if (!t[WIDTH])
            div_step = {t[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            div_step = {p[2*WIDTH-2:WIDTH-1], p[WIDTH-2:0], 1'b0};
    endfunction

    assign part_step = div_step(part, dvsr);

    // State register; reset abandons any division in progress.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (divisor == '0) ? ZERO : RUN;
            end
            RUN: begin
                if (cnt == LAST_CNT)
                    state_nxt = DONE;
            end
            ZERO:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand capture, iteration and result registers; results are written
    // only on the way into DONE and hold until the next completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            part        <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr        <= divisor;
                        part        <= {{WIDTH{1'b0}}, dividend};
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    part <= part_step;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        quotient    <= part_step[WIDTH-1:0];
                        remainder   <= part_step[2*WIDTH-1:WIDTH];
                        div_by_zero <= 1'b0;
                    end
                end
                ZERO: begin
                    // Partial still holds {0, dividend} from acceptance.
                    quotient    <= '1;
                    remainder   <= part[WIDTH-1:0];
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
